ahb_lite_cmd_initiator: RTL and testbench
=========================================

Name: ahb_lite_cmd_initiator

Overview:
- AHB-Lite manager (initiator) that converts a simple valid/ready command stream into single AHB-Lite transfers.
- Drives the subordinate port of the I3C core (haddr…hready) in block benches and bring-up integration.
- Returns read data and error status on a valid/ready response channel.
- One transfer outstanding at a time; handles wait states, two-cycle ERROR responses and misaligned-command rejection.

Parameters:
- AhbDataWidth, 64, HWDATA/HRDATA width in bits (32 or 64).
- AhbAddrWidth, 32, HADDR width in bits.
- WaitCntWidth, 8, width of the saturating wait-state counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_addr_i  in  AhbAddrWidth  byte address
- cmd_write_i  in  1  1=write, 0=read
- cmd_size_i  in  3  HSIZE encoding (0=byte … 3=dword)
- cmd_wdata_i  in  AhbDataWidth  write data
- cmd_wstrb_i  in  AhbDataWidth/8  write strobes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  AhbDataWidth  read data (0 for writes/errors)
- rsp_err_o  out  1  HRESP error or misaligned
- rsp_misaligned_o  out  1  command rejected before reaching the bus
- rsp_wait_o  out  WaitCntWidth  data-phase wait cycles (saturating)
- haddr_o  out  AhbAddrWidth  HADDR
- hburst_o  out  3  fixed 3'b000 (SINGLE)
- hprot_o  out  4  fixed 4'b0011
- hsize_o  out  3  HSIZE
- htrans_o  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- hwrite_o  out  1  HWRITE
- hwdata_o  out  AhbDataWidth  HWDATA
- hwstrb_o  out  AhbDataWidth/8  HWSTRB
- hsel_o  out  1  HSEL
- hrdata_i  in  AhbDataWidth  HRDATA
- hready_i  in  1  bus HREADY
- hresp_i  in  1  HRESP

Behaviour:
- Clock/reset: single clock clk_i; rst_ni asynchronous, active-low.
- Reset values: all outputs 0, except hprot_o=4'b0011; state IDLE.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch all cmd fields.
  - If misaligned (addr[size-1:0]!=0, or size > log2(AhbDataWidth/8)): go to RESP with err=1, misaligned=1, wait=0; no bus activity.
  - Otherwise go to ADDR.
- ADDR:
  - htrans_o=NONSEQ, hsel_o=1; haddr/hsize/hwrite from latched command.
  - Hold these until hready_i=1, then go to DATA.
  - hready_i low in ADDR is the previous transfer's tail; keep the address stable.
- DATA:
  - htrans_o=IDLE, hsel_o=0; hwdata_o/hwstrb_o driven from latch when write, else 0.
  - Wait counter increments on each cycle with hready_i=0 and saturates at all-ones.
  - hresp_i=1 with hready_i=0 is the first ERROR cycle; record err. htrans is already IDLE, so no cancel is required.
  - On hready_i=1, capture hrdata_i (reads with no error only; else 0) and err|=hresp_i, then go to RESP.
- RESP:
  - rsp_valid_o=1; all rsp_* outputs stable until rsp_ready_i.
  - On handshake, go to IDLE.
  - No same-cycle re-accept: cmd_ready_o=0 outside IDLE.
- Latency (zero-wait subordinate, rsp_ready_i=1): command accept → ADDR → DATA → RESP gives rsp_valid 3 cycles after accept. Back-to-back command throughput is 1 per 4 cycles.
- Bus outputs in IDLE/RESP: htrans=IDLE, hsel=0, haddr held at last value.
- Reset mid-transfer: everything returns to reset values immediately; no response is produced for the aborted command.
- Widths: hsize_o passes cmd_size_i through. Misalignment check uses only the low log2(AhbDataWidth/8) address bits.

Decomposition:
- Shared package ahb_lite_pkg:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ)
  - hsize constants
  - HBURST_SINGLE, HPROT_DEFAULT
  - cmd_t / rsp_t packed structs
- No sub-module required. The saturating counter is inline.
- Bench pairs this block with i3c_wrapper as the DUT end.

Test Plan:
- Write addr 0x10, size 2, wdata 0xDEADBEEF, strb 0x0F, zero-wait → htrans NONSEQ for 1 cycle, hwdata=0xDEADBEEF next cycle; rsp_valid at accept+3 with err=0, wait=0.
- Read addr 0x18 while subordinate holds hready low 3 cycles, then hrdata=0x1234 → rsp_rdata=0x1234, wait=3, address phase stable throughout.
- Subordinate gives ERROR (hresp=1/hready=0, then hresp=1/hready=1) → rsp_err=1, misaligned=0, rdata=0, htrans IDLE both cycles.
- Command addr 0x13, size 2 → no NONSEQ ever driven; rsp_valid at accept+1 with err=1, misaligned=1.
- rsp_ready held low 5 cycles → rsp fields stable, cmd_ready=0; next command accepted the cycle after the response handshake.
- rst_ni low during DATA with hready stalled → outputs reset asynchronously, rsp_valid never asserts; a new command completes normally after release.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and constants for the command initiator.
// Struct field widths follow the default 64-bit data / 32-bit address configuration.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } init_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } cmd_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic        misaligned;
    logic [7:0]  wait_cnt;
  } rsp_t;

  // Largest HSIZE a bus of the given data width can carry.
  function automatic logic [2:0] max_hsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/ahb_lite_cmd_initiator.sv
// AHB-Lite manager: turns one valid/ready command into one SINGLE transfer
// and reports read data, error and wait-state count on a response channel.
module ahb_lite_cmd_initiator
  import ahb_lite_pkg::*;
#(
  parameter int unsigned AhbDataWidth = 64,
  parameter int unsigned AhbAddrWidth = 32,
  parameter int unsigned WaitCntWidth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [AhbAddrWidth-1:0]   cmd_addr_i,
  input  logic                      cmd_write_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [AhbDataWidth-1:0]   cmd_wdata_i,
  input  logic [AhbDataWidth/8-1:0] cmd_wstrb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AhbDataWidth-1:0]   rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_misaligned_o,
  output logic [WaitCntWidth-1:0]   rsp_wait_o,
  output logic [AhbAddrWidth-1:0]   haddr_o,
  output logic [2:0]                hburst_o,
  output logic [3:0]                hprot_o,
  output logic [2:0]                hsize_o,
  output logic [1:0]                htrans_o,
  output logic                      hwrite_o,
  output logic [AhbDataWidth-1:0]   hwdata_o,
  output logic [AhbDataWidth/8-1:0] hwstrb_o,
  output logic                      hsel_o,
  input  logic [AhbDataWidth-1:0]   hrdata_i,
  input  logic                      hready_i,
  input  logic                      hresp_i
);

  localparam int unsigned StrbWidth = AhbDataWidth / 8;
  localparam int unsigned LsbWidth  = $clog2(StrbWidth);
  localparam logic [2:0]  MaxSize   = max_hsize(AhbDataWidth);
  localparam logic [WaitCntWidth-1:0] WaitOne = {{(WaitCntWidth-1){1'b0}}, 1'b1};

  init_state_e             state_q;
  logic                    cmd_ready_q;
  logic                    wr_q;
  logic [AhbDataWidth-1:0] wdata_q;
  logic [StrbWidth-1:0]    wstrb_q;
  logic                    rsp_valid_q;
  logic [AhbDataWidth-1:0] rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_misaligned_q;
  logic [WaitCntWidth-1:0] rsp_wait_q;
  logic [AhbAddrWidth-1:0] haddr_q;
  logic [2:0]              hsize_q;
  htrans_e                 htrans_q;
  logic                    hwrite_q;
  logic [AhbDataWidth-1:0] hwdata_q;
  logic [StrbWidth-1:0]    hwstrb_q;
  logic                    hsel_q;

  logic [LsbWidth-1:0]     size_mask_d;
  logic                    misaligned_d;

  // Only the byte-lane bits of the address take part in the alignment check.
  always_comb begin
    size_mask_d = '0;
    for (int i = 0; i < LsbWidth; i++) begin
      size_mask_d[i] = (i < int'(cmd_size_i));
    end
    misaligned_d = (cmd_size_i > MaxSize) ||
                   (|(cmd_addr_i[LsbWidth-1:0] & size_mask_d));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_IDLE;
      cmd_ready_q      <= 1'b0;
      wr_q             <= 1'b0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_err_q        <= 1'b0;
      rsp_misaligned_q <= 1'b0;
      rsp_wait_q       <= '0;
      haddr_q          <= '0;
      hsize_q          <= '0;
      htrans_q         <= HTRANS_IDLE;
      hwrite_q         <= 1'b0;
      hwdata_q         <= '0;
      hwstrb_q         <= '0;
      hsel_q           <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_ready_q && cmd_valid_i) begin
            cmd_ready_q      <= 1'b0;
            wr_q             <= cmd_write_i;
            wdata_q          <= cmd_wdata_i;
            wstrb_q          <= cmd_wstrb_i;
            rsp_rdata_q      <= '0;
            rsp_wait_q       <= '0;
            rsp_err_q        <= misaligned_d;
            rsp_misaligned_q <= misaligned_d;
            if (misaligned_d) begin
              rsp_valid_q <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              haddr_q  <= cmd_addr_i;
              hsize_q  <= cmd_size_i;
              hwrite_q <= cmd_write_i;
              htrans_q <= HTRANS_NONSEQ;
              hsel_q   <= 1'b1;
              state_q  <= ST_ADDR;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_ADDR: begin
          // A low HREADY here belongs to someone else's data phase.
          if (hready_i) begin
            htrans_q <= HTRANS_IDLE;
            hsel_q   <= 1'b0;
            hwdata_q <= wr_q ? wdata_q : '0;
            hwstrb_q <= wr_q ? wstrb_q : '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!hready_i) begin
            if (rsp_wait_q != '1) begin
              rsp_wait_q <= rsp_wait_q + WaitOne;
            end
            if (hresp_i) begin
              rsp_err_q <= 1'b1;
            end
          end else begin
            rsp_err_q   <= rsp_err_q | hresp_i;
            rsp_rdata_q <= (!wr_q && !rsp_err_q && !hresp_i) ? hrdata_i : '0;
            hwdata_q    <= '0;
            hwstrb_q    <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign rsp_err_o        = rsp_err_q;
  assign rsp_misaligned_o = rsp_misaligned_q;
  assign rsp_wait_o       = rsp_wait_q;
  assign haddr_o          = haddr_q;
  assign hburst_o         = HBURST_SINGLE;
  assign hprot_o          = HPROT_DEFAULT;
  assign hsize_o          = hsize_q;
  assign htrans_o         = htrans_q;
  assign hwrite_o         = hwrite_q;
  assign hwdata_o         = hwdata_q;
  assign hwstrb_o         = hwstrb_q;
  assign hsel_o           = hsel_q;

endmodule

// File: tb/tb_ahb_lite_cmd_initiator.sv
// Directed bench for the AHB-Lite command initiator; the bench itself plays the subordinate.
module tb_ahb_lite_cmd_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic        cmd_write_i = 1'b0;
  logic [2:0]  cmd_size_i = '0;
  logic [63:0] cmd_wdata_i = '0;
  logic [7:0]  cmd_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_misaligned_o;
  logic [7:0]  rsp_wait_o;
  logic [31:0] haddr_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic [2:0]  hsize_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [63:0] hwdata_o;
  logic [7:0]  hwstrb_o;
  logic        hsel_o;
  logic [63:0] hrdata_i = '0;
  logic        hready_i = 1'b1;
  logic        hresp_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ahb_lite_cmd_initiator #(
    .AhbDataWidth(64),
    .AhbAddrWidth(32),
    .WaitCntWidth(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_write_i(cmd_write_i), .cmd_size_i(cmd_size_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_misaligned_o(rsp_misaligned_o), .rsp_wait_o(rsp_wait_o),
    .haddr_o(haddr_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hsize_o(hsize_o),
    .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hwdata_o(hwdata_o), .hwstrb_o(hwstrb_o),
    .hsel_o(hsel_o), .hrdata_i(hrdata_i), .hready_i(hready_i), .hresp_i(hresp_i)
  );

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Presents a command for exactly one rising edge; caller ensures cmd_ready is high.
  task automatic send_cmd(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [63:0] wdata, input logic [7:0] wstrb);
    cmd_addr_i  = addr;
    cmd_write_i = wr;
    cmd_size_i  = size;
    cmd_wdata_i = wdata;
    cmd_wstrb_i = wstrb;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0h expected 0", cmd_ready_o); end
    checks++; if (htrans_o !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %0h expected 0", htrans_o); end
    checks++; if (hprot_o !== 4'b0011) begin errors++; $display("FAIL rst_hprot: got %0h expected 3", hprot_o); end
    checks++; if (rsp_valid_o !== 1'b0 || hsel_o !== 1'b0 || haddr_o !== 32'h0) begin
      errors++; $display("FAIL rst_outputs: got valid=%0h hsel=%0h haddr=%0h expected 0/0/0", rsp_valid_o, hsel_o, haddr_o); end
    rst_ni = 1'b1;
    tick();
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %0h expected 1", cmd_ready_o); end
    $display("reset: released, cmd_ready=%0h", cmd_ready_o);
  endtask

  task automatic test_write_zero_wait();
    send_cmd(32'h10, 1'b1, 3'd2, 64'hDEADBEEF, 8'h0F);
    checks++; if (htrans_o !== 2'b10 || hsel_o !== 1'b1) begin
      errors++; $display("FAIL wr_addr_phase: got htrans=%0h hsel=%0h expected 2/1", htrans_o, hsel_o); end
    checks++; if (haddr_o !== 32'h10 || hsize_o !== 3'd2 || hwrite_o !== 1'b1 || hburst_o !== 3'b000) begin
      errors++; $display("FAIL wr_addr_fields: got haddr=%0h hsize=%0h hwrite=%0h hburst=%0h expected 10/2/1/0", haddr_o, hsize_o, hwrite_o, hburst_o); end
    checks++; if (cmd_ready_o !== 1'b0) begin errors++; $display("FAIL wr_ready_busy: got %0h expected 0", cmd_ready_o); end
    tick();
    checks++; if (htrans_o !== 2'b00 || hsel_o !== 1'b0) begin
      errors++; $display("FAIL wr_data_htrans: got htrans=%0h hsel=%0h expected 0/0", htrans_o, hsel_o); end
    checks++; if (hwdata_o !== 64'hDEADBEEF || hwstrb_o !== 8'h0F) begin
      errors++; $display("FAIL wr_hwdata: got %0h/%0h expected deadbeef/0f", hwdata_o, hwstrb_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_early: got %0h expected 0", rsp_valid_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_wait_o !== 8'd0 || rsp_rdata_o !== 64'h0) begin
      errors++; $display("FAIL wr_rsp: got valid=%0h err=%0h wait=%0d rdata=%0h expected 1/0/0/0", rsp_valid_o, rsp_err_o, rsp_wait_o, rsp_rdata_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL wr_back_idle: got valid=%0h ready=%0h expected 0/1", rsp_valid_o, cmd_ready_o); end
    $display("write: addr=0x10 data=0xdeadbeef err=%0h wait=%0d", rsp_err_o, rsp_wait_o);
  endtask

  task automatic test_read_wait();
    send_cmd(32'h18, 1'b0, 3'd3, 64'h0, 8'h0);
    hready_i = 1'b0;
    tick();
    checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h18 || hsize_o !== 3'd3 || hwrite_o !== 1'b0) begin
      errors++; $display("FAIL rd_addr_hold: got htrans=%0h haddr=%0h hsize=%0h hwrite=%0h expected 2/18/3/0", htrans_o, haddr_o, hsize_o, hwrite_o); end
    hready_i = 1'b1;
    tick();
    hready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (htrans_o !== 2'b00 || hsel_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
        errors++; $display("FAIL rd_stall_%0d: got htrans=%0h hsel=%0h valid=%0h expected 0/0/0", i, htrans_o, hsel_o, rsp_valid_o); end
      tick();
    end
    hready_i = 1'b1;
    hrdata_i = 64'h1234;
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'h1234 || rsp_wait_o !== 8'd3 || rsp_err_o !== 1'b0) begin
      errors++; $display("FAIL rd_rsp: got valid=%0h rdata=%0h wait=%0d err=%0h expected 1/1234/3/0", rsp_valid_o, rsp_rdata_o, rsp_wait_o, rsp_err_o); end
    tick();
    $display("read: addr=0x18 rdata=0x1234 wait=3");
  endtask

  task automatic test_error();
    hrdata_i = 64'hFFFF;
    send_cmd(32'h20, 1'b0, 3'd2, 64'h0, 8'h0);
    tick();
    hready_i = 1'b0;
    hresp_i  = 1'b1;
    checks++; if (htrans_o !== 2'b00) begin errors++; $display("FAIL err_htrans_1: got %0h expected 0", htrans_o); end
    tick();
    hready_i = 1'b1;
    checks++; if (htrans_o !== 2'b00 || rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL err_htrans_2: got htrans=%0h valid=%0h expected 0/0", htrans_o, rsp_valid_o); end
    tick();
    hresp_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_misaligned_o !== 1'b0 || rsp_rdata_o !== 64'h0 || rsp_wait_o !== 8'd1) begin
      errors++; $display("FAIL err_rsp: got valid=%0h err=%0h mis=%0h rdata=%0h wait=%0d expected 1/1/0/0/1", rsp_valid_o, rsp_err_o, rsp_misaligned_o, rsp_rdata_o, rsp_wait_o); end
    tick();
    $display("error: addr=0x20 err=1");
  endtask

  task automatic test_misaligned();
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL mis_ready: got %0h expected 1", cmd_ready_o); end
    send_cmd(32'h13, 1'b0, 3'd2, 64'h0, 8'h0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_misaligned_o !== 1'b1 || rsp_wait_o !== 8'd0) begin
      errors++; $display("FAIL mis_rsp: got valid=%0h err=%0h mis=%0h wait=%0d expected 1/1/1/0", rsp_valid_o, rsp_err_o, rsp_misaligned_o, rsp_wait_o); end
    checks++; if (htrans_o !== 2'b00 || hsel_o !== 1'b0 || haddr_o !== 32'h20) begin
      errors++; $display("FAIL mis_no_bus: got htrans=%0h hsel=%0h haddr=%0h expected 0/0/20", htrans_o, hsel_o, haddr_o); end
    tick();
    send_cmd(32'h0, 1'b0, 3'd4, 64'h0, 8'h0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_misaligned_o !== 1'b1 || htrans_o !== 2'b00) begin
      errors++; $display("FAIL mis_oversize: got valid=%0h mis=%0h htrans=%0h expected 1/1/0", rsp_valid_o, rsp_misaligned_o, htrans_o); end
    tick();
    $display("misaligned: addr=0x13 size=2 and addr=0x0 size=4 rejected");
  endtask

  task automatic test_back_to_back();
    rsp_ready_i = 1'b0;
    hrdata_i = 64'hAB;
    send_cmd(32'h8, 1'b0, 3'd0, 64'h0, 8'h0);
    tick();
    tick();
    cmd_addr_i  = 32'h44;
    cmd_write_i = 1'b1;
    cmd_size_i  = 3'd2;
    cmd_wdata_i = 64'h55;
    cmd_wstrb_i = 8'h0F;
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 64'hAB || rsp_err_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%0h rdata=%0h err=%0h ready=%0h expected 1/ab/0/0", i, rsp_valid_o, rsp_rdata_o, rsp_err_o, cmd_ready_o); end
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    checks++; if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%0h ready=%0h expected 0/1", rsp_valid_o, cmd_ready_o); end
    tick();
    cmd_valid_i = 1'b0;
    checks++; if (htrans_o !== 2'b10 || haddr_o !== 32'h44 || hwrite_o !== 1'b1) begin
      errors++; $display("FAIL bp_next_addr: got htrans=%0h haddr=%0h hwrite=%0h expected 2/44/1", htrans_o, haddr_o, hwrite_o); end
    tick();
    checks++; if (hwdata_o !== 64'h55) begin errors++; $display("FAIL bp_next_data: got %0h expected 55", hwdata_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_rdata_o !== 64'h0) begin
      errors++; $display("FAIL bp_next_rsp: got valid=%0h err=%0h rdata=%0h expected 1/0/0", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    tick();
    $display("back_to_back: read 0x8 rdata=0xab held 5 cycles, then write 0x44");
  endtask

  task automatic test_reset_mid_transfer();
    send_cmd(32'h50, 1'b0, 3'd2, 64'h0, 8'h0);
    tick();
    hready_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    checks++; if (htrans_o !== 2'b00 || hsel_o !== 1'b0 || haddr_o !== 32'h0 || cmd_ready_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_bus: got htrans=%0h hsel=%0h haddr=%0h ready=%0h expected 0/0/0/0", htrans_o, hsel_o, haddr_o, cmd_ready_o); end
    checks++; if (rsp_valid_o !== 1'b0 || rsp_wait_o !== 8'd0 || hprot_o !== 4'b0011) begin
      errors++; $display("FAIL mid_rst_rsp: got valid=%0h wait=%0d hprot=%0h expected 0/0/3", rsp_valid_o, rsp_wait_o, hprot_o); end
    hready_i = 1'b1;
    tick();
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_no_rsp_%0d: got %0h expected 0", i, rsp_valid_o); end
    end
    checks++; if (cmd_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0h expected 1", cmd_ready_o); end
    send_cmd(32'h30, 1'b1, 3'd2, 64'hCAFE, 8'h0F);
    tick();
    checks++; if (hwdata_o !== 64'hCAFE) begin errors++; $display("FAIL mid_rst_new_data: got %0h expected cafe", hwdata_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0 || rsp_wait_o !== 8'd0) begin
      errors++; $display("FAIL mid_rst_new_rsp: got valid=%0h err=%0h wait=%0d expected 1/0/0", rsp_valid_o, rsp_err_o, rsp_wait_o); end
    tick();
    $display("reset_mid_transfer: aborted read 0x50, then write 0x30 completed");
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_error();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
